uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_frm_buf.sv | 22 ++
 rtl/uart_rx_frame_ctrl.sv | 155 +++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive framing logic: FSM states, the
// start-of-frame marker, error cause codes and a width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_LEN = 3'd1,
    ST_GET_PAY = 3'd2,
    ST_GET_CHK = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  localparam logic [7:0] SOF = 8'hA5;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_BAD_LEN  = 3'd1,
    ERR_BAD_CHK  = 3'd2,
    ERR_TIMEOUT  = 3'd3,
    ERR_LINE     = 3'd4,
    ERR_OVERRUN  = 3'd5
  } err_t;

  // Bits needed to address v distinct values; never less than 1.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < 64; i++) begin
      if ((64'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_frm_buf.sv
// Payload register file: synchronous write, asynchronous read, no reset.
module uart_frm_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          Clk_RX,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge Clk_RX) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame assembler: SOF / LEN / payload / XOR checksum, holds a checked frame
// for a valid/ready consumer and reports aborts and dropped bytes.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned BAUD_RATE    = 115200,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic       Clk_RX,
  input  logic       Reset_R,
  input  logic       Rx_Valid,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_Err,
  output logic       Rx_En,
  output logic       Frm_Valid,
  input  logic       Frm_Ready,
  output logic [4:0] Frm_Len,
  input  logic [3:0] Rd_Addr,
  output logic [7:0] Rd_Data,
  output logic       Err_Pulse,
  output logic [2:0] Err_Code,
  output logic [7:0] Err_Cnt
);

  localparam longint unsigned TMO_LIMIT =
    (64'(TIMEOUT_BITS) * 64'(CLK_FREQ)) / 64'(BAUD_RATE);
  localparam int unsigned TW = clog2(TMO_LIMIT + 1);
  localparam int unsigned AW = clog2(MAX_LEN);

  state_t        state;
  logic [AW-1:0] idx;
  logic [7:0]    chk;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          last_byte;
  logic          err_set;
  err_t          err_val;
  logic          buf_we;
  logic [7:0]    buf_rd;

  assign tmo_hit   = (tmo_cnt == TW'(TMO_LIMIT - 1));
  assign last_byte = (5'(idx) == (Frm_Len - 5'd1));
  assign buf_we    = (state == ST_GET_PAY) && Rx_Valid && !Rx_Err;

  // Line errors take priority over content checks; timeout only fires on an idle cycle.
  always_comb begin
    err_set = 1'b0;
    err_val = ERR_NONE;
    unique case (state)
      ST_IDLE: ;
      ST_HOLD: begin
        if (Rx_Valid) begin
          err_set = 1'b1;
          err_val = ERR_OVERRUN;
        end
      end
      default: begin
        if (Rx_Valid && Rx_Err) begin
          err_set = 1'b1;
          err_val = ERR_LINE;
        end else if (Rx_Valid) begin
          if (state == ST_GET_LEN && (Rx_Data == 8'd0 || 32'(Rx_Data) > MAX_LEN)) begin
            err_set = 1'b1;
            err_val = ERR_BAD_LEN;
          end else if (state == ST_GET_CHK && Rx_Data != chk) begin
            err_set = 1'b1;
            err_val = ERR_BAD_CHK;
          end
        end else if (tmo_hit) begin
          err_set = 1'b1;
          err_val = ERR_TIMEOUT;
        end
      end
    endcase
  end

  always_ff @(posedge Clk_RX or posedge Reset_R) begin
    if (Reset_R) begin
      state     <= ST_IDLE;
      idx       <= '0;
      chk       <= '0;
      tmo_cnt   <= '0;
      Rx_En     <= 1'b1;
      Frm_Valid <= 1'b0;
      Frm_Len   <= '0;
      Err_Pulse <= 1'b0;
      Err_Code  <= '0;
      Err_Cnt   <= '0;
    end else begin
      Err_Pulse <= err_set;
      if (err_set) begin
        Err_Code <= err_val;
        if (Err_Cnt != '1) Err_Cnt <= Err_Cnt + 8'd1;
      end

      if (state == ST_IDLE || state == ST_HOLD || Rx_Valid || err_set)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TW'(1);

      unique case (state)
        ST_IDLE: begin
          if (Rx_Valid && !Rx_Err && Rx_Data == SOF) state <= ST_GET_LEN;
        end
        ST_GET_LEN: begin
          if (err_set) state <= ST_IDLE;
          else if (Rx_Valid) begin
            Frm_Len <= Rx_Data[4:0];
            idx     <= '0;
            chk     <= Rx_Data;
            state   <= ST_GET_PAY;
          end
        end
        ST_GET_PAY: begin
          if (err_set) state <= ST_IDLE;
          else if (Rx_Valid) begin
            chk <= chk ^ Rx_Data;
            if (last_byte) state <= ST_GET_CHK;
            else           idx   <= idx + AW'(1);
          end
        end
        ST_GET_CHK: begin
          if (err_set) state <= ST_IDLE;
          else if (Rx_Valid) begin
            state     <= ST_HOLD;
            Frm_Valid <= 1'b1;
            Rx_En     <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (Frm_Ready) begin
            state     <= ST_IDLE;
            Frm_Valid <= 1'b0;
            Rx_En     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_frm_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .Clk_RX (Clk_RX),
    .we     (buf_we),
    .waddr  (idx),
    .wdata  (Rx_Data),
    .raddr  (Rd_Addr[AW-1:0]),
    .rdata  (buf_rd)
  );

  assign Rd_Data = ({1'b0, Rd_Addr} < Frm_Len) ? buf_rd : 8'h00;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: good frames, each abort cause,
// overrun, early ready, mid-frame reset and error-count saturation.
module tb_uart_rx_frame_ctrl;

  logic       Clk_RX = 1'b0;
  logic       Reset_R;
  logic       Rx_Valid;
  logic [7:0] Rx_Data;
  logic       Rx_Err;
  logic       Rx_En;
  logic       Frm_Valid;
  logic       Frm_Ready;
  logic [4:0] Frm_Len;
  logic [3:0] Rd_Addr;
  logic [7:0] Rd_Data;
  logic       Err_Pulse;
  logic [2:0] Err_Code;
  logic [7:0] Err_Cnt;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;
  int pc0;
  logic [7:0] x;

  always #5 Clk_RX = ~Clk_RX;

  uart_rx_frame_ctrl #(
    .CLK_FREQ(50_000_000), .BAUD_RATE(115200), .MAX_LEN(16), .TIMEOUT_BITS(20)
  ) dut (
    .Clk_RX(Clk_RX), .Reset_R(Reset_R), .Rx_Valid(Rx_Valid), .Rx_Data(Rx_Data),
    .Rx_Err(Rx_Err), .Rx_En(Rx_En), .Frm_Valid(Frm_Valid), .Frm_Ready(Frm_Ready),
    .Frm_Len(Frm_Len), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .Err_Pulse(Err_Pulse),
    .Err_Code(Err_Code), .Err_Cnt(Err_Cnt)
  );

  always @(negedge Clk_RX) if (Err_Pulse === 1'b1) pulse_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic e = 1'b0);
    @(negedge Clk_RX);
    Rx_Valid = 1'b1; Rx_Data = b; Rx_Err = e;
    @(negedge Clk_RX);
    Rx_Valid = 1'b0; Rx_Err = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    Rd_Addr = a;
    #1;
    chk(tag, 32'(Rd_Data), 32'(exp));
  endtask

  task automatic handshake();
    @(negedge Clk_RX);
    Frm_Ready = 1'b1;
    @(negedge Clk_RX);
    Frm_Ready = 1'b0;
    chk("hs_valid_low", 32'(Frm_Valid), 0);
    chk("hs_rx_en", 32'(Rx_En), 1);
  endtask

  initial begin
    Reset_R = 1'b1; Rx_Valid = 1'b0; Rx_Data = '0; Rx_Err = 1'b0;
    Frm_Ready = 1'b0; Rd_Addr = '0;
    repeat (2) @(negedge Clk_RX);
    chk("rst_rx_en", 32'(Rx_En), 1);
    chk("rst_frm_valid", 32'(Frm_Valid), 0);
    chk("rst_frm_len", 32'(Frm_Len), 0);
    chk("rst_err_pulse", 32'(Err_Pulse), 0);
    chk("rst_err_code", 32'(Err_Code), 0);
    chk("rst_err_cnt", 32'(Err_Cnt), 0);
    Reset_R = 1'b0;

    // Good frame A5 02 11 22 31
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22);
    chk("good_not_yet", 32'(Frm_Valid), 0);
    send(8'h31);
    chk("good_valid", 32'(Frm_Valid), 1);
    chk("good_len", 32'(Frm_Len), 2);
    chk("good_rx_en", 32'(Rx_En), 0);
    rd("good_rd0", 4'd0, 8'h11);
    rd("good_rd1", 4'd1, 8'h22);
    rd("good_rd2_oob", 4'd2, 8'h00);
    repeat (5) @(negedge Clk_RX);
    chk("good_still_valid", 32'(Frm_Valid), 1);
    chk("good_still_rx_en", 32'(Rx_En), 0);
    chk("good_no_err", 32'(Err_Cnt), 0);
    handshake();

    // Bad checksum
    pc0 = pulse_cnt;
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22); send(8'h30);
    repeat (3) @(negedge Clk_RX);
    chk("chk_no_valid", 32'(Frm_Valid), 0);
    chk("chk_code", 32'(Err_Code), 2);
    chk("chk_cnt", 32'(Err_Cnt), 1);
    chk("chk_pulses", 32'(pulse_cnt - pc0), 1);

    // Bad lengths: 0 and 17
    send(8'hA5); send(8'h00);
    chk("len0_code", 32'(Err_Code), 1);
    chk("len0_cnt", 32'(Err_Cnt), 2);
    send(8'hA5); send(8'h11);
    chk("len17_code", 32'(Err_Code), 1);
    chk("len17_cnt", 32'(Err_Cnt), 3);

    // Maximum length frame of 16 bytes
    x = 8'h10;
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) begin
      send(8'(i * 3 + 1));
      x = x ^ 8'(i * 3 + 1);
    end
    send(x);
    chk("max_valid", 32'(Frm_Valid), 1);
    chk("max_len", 32'(Frm_Len), 16);
    rd("max_rd0", 4'd0, 8'h01);
    rd("max_rd15", 4'd15, 8'h2E);
    chk("max_cnt", 32'(Err_Cnt), 3);
    handshake();

    // Overrun in HOLD, then overrun in the handshake cycle
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    chk("ovr_valid", 32'(Frm_Valid), 1);
    send(8'h55);
    chk("ovr_code", 32'(Err_Code), 5);
    chk("ovr_cnt", 32'(Err_Cnt), 4);
    chk("ovr_still_valid", 32'(Frm_Valid), 1);
    chk("ovr_len", 32'(Frm_Len), 1);
    rd("ovr_rd0", 4'd0, 8'h7E);
    @(negedge Clk_RX);
    Frm_Ready = 1'b1; Rx_Valid = 1'b1; Rx_Data = 8'h66;
    @(negedge Clk_RX);
    Frm_Ready = 1'b0; Rx_Valid = 1'b0;
    chk("ovr_hs_valid", 32'(Frm_Valid), 0);
    chk("ovr_hs_cnt", 32'(Err_Cnt), 5);
    chk("ovr_hs_code", 32'(Err_Code), 5);

    // Ready held high before the frame completes
    Frm_Ready = 1'b1;
    send(8'hA5); send(8'h01); send(8'h42); send(8'h43);
    chk("early_first_hold", 32'(Frm_Valid), 1);
    @(negedge Clk_RX);
    chk("early_done", 32'(Frm_Valid), 0);
    chk("early_rx_en", 32'(Rx_En), 1);
    Frm_Ready = 1'b0;

    // Inter-byte timeout
    send(8'hA5); send(8'h03); send(8'h01);
    repeat (8600) @(negedge Clk_RX);
    chk("tmo_not_yet", 32'(Err_Cnt), 5);
    repeat (200) @(negedge Clk_RX);
    chk("tmo_cnt", 32'(Err_Cnt), 6);
    chk("tmo_code", 32'(Err_Code), 3);
    send(8'hA5); send(8'h01); send(8'h09); send(8'h08);
    chk("tmo_idle_then_frame", 32'(Frm_Valid), 1);
    handshake();

    // Line error mid-payload
    send(8'hA5); send(8'h02); send(8'h11); send(8'h22, 1'b1);
    chk("line_code", 32'(Err_Code), 4);
    chk("line_cnt", 32'(Err_Cnt), 7);

    // Reset in the middle of a payload
    send(8'hA5); send(8'h03); send(8'h01);
    pc0 = pulse_cnt;
    @(negedge Clk_RX);
    Reset_R = 1'b1;
    #1;
    chk("mrst_cnt", 32'(Err_Cnt), 0);
    chk("mrst_code", 32'(Err_Code), 0);
    chk("mrst_len", 32'(Frm_Len), 0);
    chk("mrst_valid", 32'(Frm_Valid), 0);
    chk("mrst_rx_en", 32'(Rx_En), 1);
    rd("mrst_rd", 4'd0, 8'h00);
    @(negedge Clk_RX);
    Reset_R = 1'b0;
    repeat (3) @(negedge Clk_RX);
    chk("mrst_no_pulse", 32'(pulse_cnt - pc0), 0);
    chk("mrst_cnt_after", 32'(Err_Cnt), 0);

    // Saturation after 260 bad-length frames
    for (int i = 0; i < 260; i++) begin
      send(8'hA5); send(8'h00);
    end
    chk("sat_cnt", 32'(Err_Cnt), 255);
    chk("sat_code", 32'(Err_Code), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
